// File: rtl/keypad_pkg.sv
// Shared constants for the keypad entry block: key codes, keypad layout,
// debounce state encoding and per-scan classification encoding.
package keypad_pkg;

    // Function keys with a dedicated action in the operand logic
    localparam logic [3:0] KEY_ENTER = 4'd10;  // toggle A/B selection
    localparam logic [3:0] KEY_CLEAR = 4'd11;  // clear selected operand
    localparam logic [3:0] KEY_START = 4'd12;  // request a computation

    // Position p = 4*row + col to key code; entry 0 is the rightmost nibble
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    // Debounce states
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PRESS_CNT = 2'd1;
    localparam logic [1:0] ST_HELD      = 2'd2;
    localparam logic [1:0] ST_REL_CNT   = 2'd3;

    // Result of one complete four-column scan
    localparam logic [1:0] SCAN_NONE   = 2'd0;
    localparam logic [1:0] SCAN_SINGLE = 2'd1;
    localparam logic [1:0] SCAN_MULTI  = 2'd2;

endpackage

// File: rtl/keypad_scan.sv
// Column strobe, row sampling, scan classification and press/release
// debounce. Exposes the combinational accept strobe so the operand logic can
// act on the same edge that raises key_valid.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rows,
    output logic [3:0] col_sel,
    output logic       accept,
    output logic [3:0] accept_code,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam int unsigned DivW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);

    logic [DivW-1:0] div_q;
    logic [1:0]      col_q;
    logic [1:0]      hits_q;     // keys seen so far this scan, saturating at 2
    logic [3:0]      pos_q;      // position of the (single) key seen so far
    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      cand_q, cand_d;
    logic            key_valid_q, key_valid_d;
    logic [3:0]      key_code_q, key_code_d;

    logic            sample, scan_done;
    logic [2:0]      row_cnt, hit_sum;
    logic [1:0]      hits_new, row_idx, scan_res;
    logic [3:0]      pos_new, scan_code;

    assign sample    = (div_q == DivW'(SCAN_DIV - 1));
    assign scan_done = sample && (col_q == 2'd3);
    assign col_sel   = 4'b0001 << col_q;

    // Merge the current column's rows into the running scan result
    always_comb begin
        row_cnt = {2'b0, rows[0]} + {2'b0, rows[1]} + {2'b0, rows[2]} + {2'b0, rows[3]};
        hit_sum = {1'b0, hits_q} + row_cnt;
        hits_new = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        case (rows)
            4'b0010: row_idx = 2'd1;
            4'b0100: row_idx = 2'd2;
            4'b1000: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
        pos_new = (row_cnt == 3'd1) ? {row_idx, col_q} : pos_q;
        unique case (hits_new)
            2'd0:    scan_res = SCAN_NONE;
            2'd1:    scan_res = SCAN_SINGLE;
            default: scan_res = SCAN_MULTI;
        endcase
        scan_code = KEY_MAP[pos_new];
    end

    // Column timing and per-scan accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            col_q  <= 2'd0;
            hits_q <= 2'd0;
            pos_q  <= 4'd0;
        end else begin
            div_q <= sample ? '0 : div_q + 1'b1;
            if (sample) begin
                col_q  <= col_q + 2'd1;
                hits_q <= scan_done ? 2'd0 : hits_new;
                pos_q  <= scan_done ? 4'd0 : pos_new;
            end
        end
    end

    // Debounce next state; only advances once per completed scan
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        if (scan_done) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_res == SCAN_SINGLE) begin
                        cand_d = scan_code;
                        cnt_d  = CntW'(1);
                        if (DEBOUNCE_SCANS <= 1) begin
                            state_d     = ST_HELD;
                            key_valid_d = 1'b1;
                            key_code_d  = scan_code;
                        end else begin
                            state_d = ST_PRESS_CNT;
                        end
                    end
                end
                ST_PRESS_CNT: begin
                    if (scan_res == SCAN_SINGLE && scan_code == cand_q) begin
                        cnt_d = cnt_q + CntW'(1);
                        if (32'(cnt_q) + 32'd1 >= DEBOUNCE_SCANS) begin
                            state_d     = ST_HELD;
                            key_valid_d = 1'b1;
                            key_code_d  = cand_q;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    // MULTI keeps us here: a second key is not a release
                    if (scan_res == SCAN_NONE) begin
                        cnt_d   = CntW'(1);
                        state_d = (DEBOUNCE_SCANS <= 1) ? ST_IDLE : ST_REL_CNT;
                    end
                end
                default: begin
                    if (scan_res == SCAN_NONE) begin
                        cnt_d = cnt_q + CntW'(1);
                        if (32'(cnt_q) + 32'd1 >= DEBOUNCE_SCANS) state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HELD;
                    end
                end
            endcase
        end
    end

    // Debounce state and accepted-key registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cand_q      <= 4'd0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    assign accept      = key_valid_d;
    assign accept_code = key_code_d;
    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: turns debounced key codes into two 3-digit BCD operands,
// the A/B selection flag and a one-cycle start request.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rows,
    output logic [3:0] col_sel,
    input  logic       finish,
    output logic [3:0] num_A2,
    output logic [3:0] num_A1,
    output logic [3:0] num_A0,
    output logic [3:0] num_B2,
    output logic [3:0] num_B1,
    output logic [3:0] num_B0,
    output logic       num_display,
    output logic       start,
    output logic       key_valid,
    output logic [3:0] key_code
);

    logic        accept;
    logic [3:0]  acc_code;
    logic [11:0] a_q, a_d, b_q, b_d;
    logic        disp_q, disp_d;
    logic        start_q, start_d;

    keypad_scan #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_scan (
        .clk        (clk),
        .rst        (rst),
        .rows       (rows),
        .col_sel    (col_sel),
        .accept     (accept),
        .accept_code(acc_code),
        .key_valid  (key_valid),
        .key_code   (key_code)
    );

    // Operand editing; acts on the accept strobe so it lands with key_valid
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        disp_d  = disp_q;
        start_d = 1'b0;
        if (accept) begin
            if (acc_code <= 4'd9) begin
                if (finish) begin
                    // A new digit after a result starts a fresh entry in A
                    a_d    = {8'h00, acc_code};
                    b_d    = 12'h000;
                    disp_d = 1'b0;
                end else if (disp_q) begin
                    b_d = {b_q[7:0], acc_code};
                end else begin
                    a_d = {a_q[7:0], acc_code};
                end
            end else begin
                case (acc_code)
                    KEY_ENTER: disp_d = ~disp_q;
                    KEY_CLEAR: begin
                        if (disp_q) b_d = 12'h000;
                        else        a_d = 12'h000;
                    end
                    KEY_START: start_d = ~finish;
                    default: ;
                endcase
            end
        end
    end

    // Operand, selection and start registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= 12'h000;
            b_q     <= 12'h000;
            disp_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            disp_q  <= disp_d;
            start_q <= start_d;
        end
    end

    assign {num_A2, num_A1, num_A0} = a_q;
    assign {num_B2, num_B1, num_B0} = b_q;
    assign num_display = disp_q;
    assign start       = start_q;

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Input-side counterpart of the seven-segment digit multiplexer: scans a 4x4 matrix keypad with a one-hot column strobe, debounces presses, and decodes them into key codes.
- Assembles two 3-digit BCD operands (A, B) plus the operand-select flag (num_display) that feed the display and arithmetic path.
- Issues a one-cycle start pulse to the compute unit.
- Consumes the compute unit's finish flag to begin a fresh entry.

Parameters:
- SCAN_DIV, 50000, clocks each column is driven (1 ms at 50 MHz); minimum 2.
- DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or a release; minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rows  in  4  keypad row lines, active-high (a pressed key connects the driven column to its row)
- col_sel  out  4  one-hot column drive
- finish  in  1  compute result valid and being displayed
- num_A2, num_A1, num_A0  out  4 each  operand A BCD digits (2 = most significant)
- num_B2, num_B1, num_B0  out  4 each  operand B BCD digits
- num_display  out  1  0 = editing/showing A, 1 = editing/showing B
- start  out  1  one-cycle compute request
- key_valid  out  1  one-cycle pulse per accepted key
- key_code  out  4  code of the last accepted key

Behaviour:
- Reset values: col_sel=4'b0001; all operand digits 0; num_display=0; start=0; key_valid=0; key_code=0; scan counters, debounce state and latched scan result cleared.
- Scanning:
  - Column index c advances 0→1→2→3→0 every SCAN_DIV clocks; col_sel = 1<<c.
  - rows is sampled on the last clock of each column period (settling).
  - Key position p = 4*row + c.
- Code map, p=0..15: 1,2,3,A(10), 4,5,6,B(11), 7,8,9,C(12), E(14,'*'),0,F(15,'#'),D(13).
- Scan classification, made after column 3 is sampled: NONE (no rows high), SINGLE(code) (exactly one key), MULTI (two or more keys). MULTI is treated as NONE for acceptance but never as a release.
- Debounce FSM, states IDLE, PRESS_CNT, HELD, REL_CNT:
  - IDLE: SINGLE(k) → PRESS_CNT, cnt=1, cand=k.
  - PRESS_CNT: SINGLE(cand) → cnt+1; on reaching DEBOUNCE_SCANS → HELD and accept cand. Any other result → IDLE.
  - HELD: NONE → REL_CNT, cnt=1. Anything else → stay; no auto-repeat.
  - REL_CNT: NONE → cnt+1; on reaching DEBOUNCE_SCANS → IDLE. Anything else → HELD.
- Acceptance:
  - key_valid pulses for one clock, on the clock after the completing scan sample.
  - key_code is updated on the same edge and holds until the next accepted key.
- Actions, applied on the same edge as key_valid:
  - digit 0-9, finish=0: shift into the selected operand: X2←X1, X1←X0, X0←key. The oldest digit is discarded.
  - digit 0-9, finish=1: all six digits cleared, num_display←0, then the digit is loaded: A0←key, A1=A2=0.
  - A: num_display toggles. Digits unchanged.
  - B: selected operand cleared to 000.
  - C: start=1 for exactly one clock. Ignored (no pulse) while finish=1.
  - D, E, F: key_valid and key_code still update; no other effect.
- An async rst mid-scan or mid-debounce returns everything to reset values immediately. A key held through reset release must re-debounce from IDLE before it is accepted.

Decomposition:
- Shared package keypad_pkg:
  - key code constants KEY_ENTER=10, KEY_CLEAR=11, KEY_START=12.
  - 16-entry position-to-code table.
  - debounce state encoding.
  - scan result encoding.
- Sub-module keypad_scan: column strobe, row sampling, classification, debounce FSM. Outputs key_valid and key_code.
- Top level: operand registers, num_display, start logic.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2):
1. Reset then run 20 clocks with no key → col_sel cycles 0001,0010,0100,1000 every 4 clocks; key_valid never asserted; all outputs 0.
2. Press '7' (row2, col0) for 3 full scans, then release → exactly one key_valid with key_code=7; A2..A0=0,0,7. Enter '4','2' → A=7,4,2. Enter '9' → A=4,2,9.
3. Enter 'A', then '5','1' → num_display=1; B=0,5,1; A unchanged. Then 'B' → B=0,0,0.
4. Press 'C' with finish=0 → start high for exactly 1 clock, coincident with key_valid. Set finish=1, press 'C' → no start. Press '3' with finish=1 → A=0,0,3; B=000; num_display=0.
5. Press '1' and '2' together for 4 scans → no key_valid. Glitch '5' for 1 scan only → no key_valid. Hold '6' for 10 scans → a single key_valid.
6. Assert rst mid-press ('8' held after 1 scan, after digits have been entered) → all outputs at reset values immediately. Keep '8' held after rst drops → key_valid only after 2 new full scans; A=0,0,8.
